// File: rtl/pitcher_pkg.sv
// Shared definitions for the pitcher front-end blocks: debouncer FSM states
// and a helper that turns millisecond timings into clock-cycle counts.
package pitcher_pkg;

    typedef enum logic [2:0] {
        WAIT_REL,
        IDLE,
        ARM,
        PRESSED,
        DISARM
    } state_e;

    localparam int unsigned CLK_HZ = 50_000_000;

    function automatic int unsigned ms_to_cyc(input int unsigned ms);
        return (CLK_HZ / 1000) * ms;
    endfunction

endpackage

// File: rtl/ask_debouncer_if.sv
// Button-side bundle of the ask debouncer: raw pin in, conditioned ask,
// debounced level and hold-off busy flag out.
interface ask_debouncer_if;

    logic btn_raw;
    logic ask;
    logic btn_level;
    logic busy;

    // Drives the raw pin and consumes the conditioned outputs.
    modport master (
        output btn_raw,
        input  ask,
        input  btn_level,
        input  busy
    );

    // The debouncer itself.
    modport slave (
        input  btn_raw,
        output ask,
        output btn_level,
        output busy
    );

endinterface

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for a single asynchronous bit. RST_VAL sets
// the level both flops take during reset so the chain starts out idle.
module sync_2ff #(
    parameter bit RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Two back-to-back flops; only r_sync is safe to use downstream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/ask_debouncer.sv
// Push-button conditioner for the pitcher ask request: synchronises the raw
// pin, debounces it with a restartable counter, emits one ask pulse per
// qualified press and blocks new asks during a hold-off window.
module ask_debouncer
    import pitcher_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC   = 500000,
    parameter int unsigned HOLDOFF_CYC    = 5000000,
    parameter bit          BTN_ACTIVE_LOW = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    ask_debouncer_if.slave bus
);

    localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);
    localparam int HO_W = (HOLDOFF_CYC > 0) ? $clog2(HOLDOFF_CYC + 1) : 1;

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);
    localparam logic [HO_W-1:0] HO_LOAD = HO_W'(HOLDOFF_CYC);
    localparam logic [HO_W-1:0] HO_ONE  = HO_W'(1);

    logic            w_sync;
    logic            w_pressed;
    logic            w_busy_eff;
    logic            w_qual_press;
    logic            w_ask_nx;
    logic            w_level_nx;
    logic [DB_W-1:0] w_cnt_inc;
    logic [DB_W-1:0] w_cnt_nx;
    state_e          w_state_nx;

    state_e          r_state;
    logic [DB_W-1:0] r_cnt;
    logic            r_level;
    logic            r_ask;
    logic [HO_W-1:0] r_hold;
    logic            r_busy;

    // Synchroniser idles at the released pin level so reset looks like "not pressed".
    sync_2ff #(
        .RST_VAL (BTN_ACTIVE_LOW)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (bus.btn_raw),
        .o_q (w_sync)
    );

    assign w_pressed = w_sync ^ BTN_ACTIVE_LOW;
    assign w_cnt_inc = r_cnt + DB_ONE;

    // A press qualifying on the edge where hold-off expires is treated as not busy.
    assign w_busy_eff = r_busy && (r_hold != HO_ONE);
    assign w_ask_nx   = w_qual_press && !w_busy_eff;

    // Next-state logic: the counter restarts whenever the sample disagrees with the level being qualified.
    always_comb begin
        w_state_nx   = r_state;
        w_cnt_nx     = r_cnt;
        w_level_nx   = r_level;
        w_qual_press = 1'b0;
        unique case (r_state)
            WAIT_REL: begin
                if (w_pressed) begin
                    w_cnt_nx = '0;
                end else if (r_cnt == DB_LAST) begin
                    w_state_nx = IDLE;
                    w_cnt_nx   = '0;
                end else begin
                    w_cnt_nx = w_cnt_inc;
                end
            end
            IDLE: begin
                w_cnt_nx = '0;
                if (w_pressed) begin
                    w_state_nx = ARM;
                end
            end
            ARM: begin
                if (!w_pressed) begin
                    w_state_nx = IDLE;
                    w_cnt_nx   = '0;
                end else if (r_cnt == DB_LAST) begin
                    w_state_nx   = PRESSED;
                    w_cnt_nx     = '0;
                    w_level_nx   = 1'b1;
                    w_qual_press = 1'b1;
                end else begin
                    w_cnt_nx = w_cnt_inc;
                end
            end
            PRESSED: begin
                w_cnt_nx = '0;
                if (!w_pressed) begin
                    w_state_nx = DISARM;
                end
            end
            DISARM: begin
                if (w_pressed) begin
                    w_state_nx = PRESSED;
                    w_cnt_nx   = '0;
                end else if (r_cnt == DB_LAST) begin
                    w_state_nx = IDLE;
                    w_cnt_nx   = '0;
                    w_level_nx = 1'b0;
                end else begin
                    w_cnt_nx = w_cnt_inc;
                end
            end
            default: begin
                w_state_nx = WAIT_REL;
                w_cnt_nx   = '0;
            end
        endcase
    end

    // FSM state, debounce counter and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= WAIT_REL;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_ask   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_level <= w_level_nx;
            r_ask   <= w_ask_nx;
        end
    end

    // Hold-off window: loaded alongside ask, busy drops on the edge the count hits zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold <= '0;
            r_busy <= 1'b0;
        end else if (w_ask_nx && (HOLDOFF_CYC != 0)) begin
            r_hold <= HO_LOAD;
            r_busy <= 1'b1;
        end else if (r_busy) begin
            r_hold <= r_hold - HO_ONE;
            if (r_hold == HO_ONE) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign bus.ask       = r_ask;
    assign bus.btn_level = r_level;
    assign bus.busy      = r_busy;

endmodule
